// File: rtl/ram_step_player_if.sv
// Bus bundle for ram_step_player: step/run control, BRAM side-write port and playback outputs.
interface ram_step_player_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              step_in;
    logic              run;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              wrap_out;

    modport master (
        output step_in, run, wr_en, wr_addr, wr_data,
        input  addr_out, data_out, data_valid, wrap_out
    );

    modport slave (
        input  step_in, run, wr_en, wr_addr, wr_data,
        output addr_out, data_out, data_valid, wrap_out
    );
endinterface

// File: rtl/ram_step_player.sv
// Steps through a BRAM one word per rising edge of the slow step strobe, with run/pause.
// Define STEP_BOUNCE_EN for ping-pong playback (adds RUN_DOWN); default is wrap-to-0.
module ram_step_player #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 15
) (
    input  logic               clk_in,
    input  logic               rst,
    ram_step_player_if.slave   bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

`ifdef STEP_BOUNCE_EN
    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;
    logic dir_q, dir_d;
`else
    typedef enum logic [1:0] {IDLE, RUN_UP} state_t;
`endif

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic              step;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              adv;
    logic              adv_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q;
    logic [DATA_W-1:0] mem_rd_q;
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    assign step = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wrap_d  = 1'b0;
        adv     = 1'b0;
`ifdef STEP_BOUNCE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.run) begin
`ifdef STEP_BOUNCE_EN
                    state_d = dir_q ? RUN_DOWN : RUN_UP;
`else
                    state_d = RUN_UP;
`endif
                end
            end
            RUN_UP: begin
                if (!bus.run) begin
                    state_d = IDLE;
                end else if (step) begin
                    adv = 1'b1;
                    if (addr_q == LAST) begin
                        wrap_d = 1'b1;
`ifdef STEP_BOUNCE_EN
                        addr_d  = LAST - 1'b1;
                        state_d = RUN_DOWN;
                        dir_d   = 1'b1;
`else
                        addr_d  = '0;
`endif
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef STEP_BOUNCE_EN
            RUN_DOWN: begin
                if (!bus.run) begin
                    state_d = IDLE;
                end else if (step) begin
                    adv = 1'b1;
                    if (addr_q == '0) begin
                        wrap_d  = 1'b1;
                        addr_d  = {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d = RUN_UP;
                        dir_d   = 1'b0;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        data_d = adv_q ? mem_rd_q : data_q;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= IDLE;
            addr_q  <= '0;
            wrap_q  <= 1'b0;
            adv_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef STEP_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            s1_q    <= bus.step_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            addr_q  <= addr_d;
            wrap_q  <= wrap_d;
            adv_q   <= adv;
            data_q  <= data_d;
            valid_q <= adv_q;
`ifdef STEP_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // BRAM is read at the same edge the address advances, so a coincident write
    // to that word is seen as old data; data_q then re-registers it one clock later.
    always_ff @(posedge clk_in) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (adv) begin
            mem_rd_q <= mem[addr_d];
        end
    end

    assign bus.addr_out   = addr_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.wrap_out   = wrap_q;
endmodule

// File: tb/tb_ram_step_player.sv
// Scoreboard bench for ram_step_player: stimulus pushes expected words, a monitor checks each data_valid.
module tb_ram_step_player;
`ifdef STEP_BOUNCE_EN
    localparam logic [3:0] TB_LAST = 4'd3;
`else
    localparam logic [3:0] TB_LAST = 4'd15;
`endif

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [7:0] exp_mem [0:15];
    logic [3:0] exp_addr = 4'd0;
    logic       wrap_seen = 1'b0;

    always #5 clk = ~clk;

    ram_step_player_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_step_player #(.ADDR_W(4), .DATA_W(8), .LAST_ADDR(int'(TB_LAST))) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    // Monitor: one scoreboard transaction per data_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            wrap_seen = 1'b0;
        end else begin
            if (bus.wrap_out) wrap_seen = 1'b1;
            if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got addr 0x%0h data 0x%0h, none expected at %0t",
                             bus.addr_out, bus.data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn  addr=0x%0h data=0x%0h wrap=%0b (exp 0x%0h 0x%0h %0b)",
                             bus.addr_out, bus.data_out, wrap_seen, e.addr, e.data, e.wrap);
                    check("sb_addr", int'(bus.addr_out), int'(e.addr));
                    check("sb_data", int'(bus.data_out), int'(e.data));
                    check("sb_wrap", int'(wrap_seen), int'(e.wrap));
                end
                wrap_seen = 1'b0;
            end
        end
    end

    // Called just after a posedge; step_in is sampled high at the next edge k.
    task automatic step_pulse(input logic wr, input logic [3:0] wa, input logic [7:0] wd);
        bus.step_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wa;
            bus.wr_data = wd;
        end
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
        bus.step_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic w);
        exp_t e;
        e.addr = a;
        e.data = exp_mem[a];
        e.wrap = w;
        exp_q.push_back(e);
    endtask

    task automatic run_step(input logic wr, input logic [3:0] wa, input logic [7:0] wd);
        logic w;
        w = (exp_addr == TB_LAST);
        exp_addr = w ? 4'd0 : exp_addr + 4'd1;
        push_exp(exp_addr, w);
        if (wr) exp_mem[wa] = wd;
        step_pulse(wr, wa, wd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  int'(bus.addr_out),   0);
        check({tag, "_data"},  int'(bus.data_out),   0);
        check({tag, "_valid"}, int'(bus.data_valid), 0);
        check({tag, "_wrap"},  int'(bus.wrap_out),   0);
    endtask

`ifdef STEP_BOUNCE_EN
    int b_addr [10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    int b_wrap [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
`endif

    initial begin
        bus.step_in = 1'b1;
        bus.run     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 8'd0;

        // Reset held with step_in high and run low.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.step_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(i);
            bus.wr_data = 8'hA0 + 8'(i);
            exp_mem[i]  = 8'hA0 + 8'(i);
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;

`ifndef STEP_BOUNCE_EN
        // Paused: 20 steps must be ignored.
        for (int i = 0; i < 20; i++) step_pulse(1'b0, 4'd0, 8'd0);
        check("idle_addr", int'(bus.addr_out), 0);

        // Exact latency of a single step.
        bus.run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_addr = 4'd1;
        push_exp(4'd1, 1'b0);
        bus.step_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lat_k1_addr", int'(bus.addr_out), 0);
        @(posedge clk); #1;
        check("lat_k2_addr", int'(bus.addr_out), 1);
        check("lat_k2_valid", int'(bus.data_valid), 0);
        @(posedge clk); #1;
        bus.step_in = 1'b0;
        check("lat_k3_valid", int'(bus.data_valid), 1);
        check("lat_k3_data", int'(bus.data_out), 8'hA1);
        @(posedge clk); #1;
        check("lat_k4_valid", int'(bus.data_valid), 0);
        check("lat_k4_hold", int'(bus.data_out), 8'hA1);
        repeat (2) @(posedge clk);
        #1;

        // Run through 15 and wrap to 0.
        for (int i = 0; i < 15; i++) run_step(1'b0, 4'd0, 8'd0);
        check("wrap_addr", int'(bus.addr_out), 0);

        // Write word 3 in the same cycle the address becomes 3.
        run_step(1'b0, 4'd0, 8'd0);
        run_step(1'b0, 4'd0, 8'd0);
        run_step(1'b1, 4'd3, 8'h55);
        for (int i = 0; i < 16; i++) run_step(1'b0, 4'd0, 8'd0);
        check("rbw_revisit", int'(bus.data_out), 8'h55);

        // Pause at 7.
        for (int i = 0; i < 4; i++) run_step(1'b0, 4'd0, 8'd0);
        bus.run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) step_pulse(1'b0, 4'd0, 8'd0);
        check("pause_addr", int'(bus.addr_out), 7);
        bus.run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_step(1'b0, 4'd0, 8'd0);
        check("resume_addr", int'(bus.addr_out), 8);
`else
        // Ping-pong over 0..3.
        bus.run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            push_exp(4'(b_addr[i]), b_wrap[i] != 0);
            step_pulse(1'b0, 4'd0, 8'd0);
        end
        check("bounce_addr", int'(bus.addr_out), 2);

        // Reset while a step is in flight; it must be discarded.
        bus.step_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.step_in = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_valid_none", exp_q.size(), 0);
        push_exp(4'd1, 1'b0);
        step_pulse(1'b0, 4'd0, 8'd0);
        push_exp(4'd2, 1'b0);
        step_pulse(1'b0, 4'd0, 8'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
